// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM, press/release strobes, press counter.
// Define BTN_DEBOUNCE_LONGPRESS_EN to build the long-press hold counter and long_o strobe.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1250000,
   parameter int unsigned LONG_CYCLES     = 125000000,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             btn_i,
   output logic             level_o,
   output logic             press_o,
   output logic             release_o,
   output logic             long_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int unsigned DcntW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DcntW-1:0] DcntLast = DcntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      StReleased,
      StPressPend,
      StPressed,
      StReleasePend
   } state_e;

   if (DEBOUNCE_CYCLES < 2) begin : gen_bad_debounce
      $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
   end
   if (LONG_CYCLES < 1) begin : gen_bad_long
      $error("btn_debounce: LONG_CYCLES must be >= 1");
   end
   if (CNT_W < 1) begin : gen_bad_cnt
      $error("btn_debounce: CNT_W must be >= 1");
   end

   logic             sync1_q;
   logic             sync2_q;
   state_e           state_q;
   logic [DcntW-1:0] dcnt_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic [CNT_W-1:0] count_q;
   logic             press_accept;
   logic             release_accept;
   logic             holding;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Decoded here so the hold counter sees the same acceptance events as the FSM.
   always_comb begin
      press_accept   = (state_q == StPressPend) && sync2_q && (dcnt_q == DcntLast);
      release_accept = (state_q == StReleasePend) && !sync2_q && (dcnt_q == DcntLast);
      holding        = (state_q == StPressed) || (state_q == StReleasePend);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StReleased;
         dcnt_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         count_q   <= '0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            StReleased: begin
               if (sync2_q) begin
                  state_q <= StPressPend;
                  dcnt_q  <= DcntW'(1);
               end
            end
            StPressPend: begin
               if (!sync2_q) begin
                  state_q <= StReleased;
                  dcnt_q  <= '0;
               end else if (press_accept) begin
                  state_q <= StPressed;
                  dcnt_q  <= '0;
                  press_q <= 1'b1;
                  level_q <= 1'b1;
                  count_q <= count_q + 1'b1;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            StPressed: begin
               if (!sync2_q) begin
                  state_q <= StReleasePend;
                  dcnt_q  <= DcntW'(1);
               end
            end
            StReleasePend: begin
               if (sync2_q) begin
                  state_q <= StPressed;
                  dcnt_q  <= '0;
               end else if (release_accept) begin
                  state_q   <= StReleased;
                  dcnt_q    <= '0;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= StReleased;
               dcnt_q  <= '0;
            end
         endcase
      end
   end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
   localparam int unsigned HcntW = $clog2(LONG_CYCLES) + 1;
   localparam logic [HcntW-1:0] HcntMax  = HcntW'(LONG_CYCLES);
   localparam logic [HcntW-1:0] HcntLast = HcntW'(LONG_CYCLES - 1);

   logic [HcntW-1:0] hcnt_q;
   logic             long_q;

   // Saturating at LONG_CYCLES makes long_o fire at most once per accepted press.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (press_accept) begin
            hcnt_q <= '0;
         end else if (holding && (hcnt_q != HcntMax)) begin
            hcnt_q <= hcnt_q + 1'b1;
            if ((hcnt_q == HcntLast) && !release_accept) begin
               long_q <= 1'b1;
            end
         end
      end
   end

   assign long_o = long_q;
`else
   logic unused_hold;
   assign unused_hold = holding;
   assign long_o      = 1'b0;
`endif

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign count_o   = count_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=4.
module tb_btn_debounce;

   localparam int unsigned Deb  = 4;
   localparam int unsigned Long = 20;
   localparam int unsigned CntW = 4;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
   localparam bit LongEn = 1'b1;
`else
   localparam bit LongEn = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic            btn;
   logic            level;
   logic            press;
   logic            rel;
   logic            lng;
   logic [CntW-1:0] count;

   int checks   = 0;
   int failures = 0;

   btn_debounce #(
      .DEBOUNCE_CYCLES(Deb),
      .LONG_CYCLES    (Long),
      .CNT_W          (CntW)
   ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .btn_i    (btn),
      .level_o  (level),
      .press_o  (press),
      .release_o(rel),
      .long_o   (lng),
      .count_o  (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] exp_v;
      rst = 1'b1;
      btn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({level, press, rel, lng, count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b lng=%b cnt=%0d want all 0",
                     i, level, press, rel, lng, count);
         end
      end
      rst = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         exp_v = {(e == 6), 1'b0, (e >= 6), 1'b0};
         checks++;
         if ({press, rel, level, lng} !== exp_v) begin
            failures++;
            $display("FAIL post_reset_press edge=%0d got prs/rel/lvl/lng=%b want %b",
                     e, {press, rel, level, lng}, exp_v);
         end
      end
      checks++;
      if (count !== 4'd1) begin
         failures++;
         $display("FAIL post_reset_count got %0d want 1", count);
      end
   endtask

   task automatic test_bounce();
      logic [7:0] pat;
      pat = 8'b0011_0011;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         btn = (i < 8) ? pat[i] : 1'b0;
         tick();
         checks++;
         if ({press, rel, level, lng, count} !== '0) begin
            failures++;
            $display("FAIL bounce_reject cyc=%0d got prs=%b rel=%b lvl=%b lng=%b cnt=%0d want all 0",
                     i, press, rel, level, lng, count);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [3:0] exp_v;
      btn = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         exp_v = {(e == 6), 1'b0, (e >= 6), (LongEn && (e == 26))};
         checks++;
         if ({press, rel, level, lng} !== exp_v) begin
            failures++;
            $display("FAIL clean_press edge=%0d got prs/rel/lvl/lng=%b want %b",
                     e, {press, rel, level, lng}, exp_v);
         end
      end
      btn = 1'b0;
      for (int f = 1; f <= 12; f++) begin
         tick();
         exp_v = {1'b0, (f == 6), (f < 6), 1'b0};
         checks++;
         if ({press, rel, level, lng} !== exp_v) begin
            failures++;
            $display("FAIL clean_release edge=%0d got prs/rel/lvl/lng=%b want %b",
                     f, {press, rel, level, lng}, exp_v);
         end
      end
      checks++;
      if (count !== 4'd1) begin
         failures++;
         $display("FAIL clean_count got %0d want 1", count);
      end
   endtask

   task automatic test_long_press();
      do_reset();
      btn = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         tick();
         checks++;
         if ({press, lng} !== {(e == 6), (LongEn && (e == 26))}) begin
            failures++;
            $display("FAIL long_hold40 edge=%0d got prs=%b lng=%b want prs=%b lng=%b",
                     e, press, lng, (e == 6), (LongEn && (e == 26)));
         end
      end
      btn = 1'b0;
      for (int f = 1; f <= 10; f++) begin
         tick();
         checks++;
         if ({rel, lng} !== {(f == 6), 1'b0}) begin
            failures++;
            $display("FAIL long_rel40 edge=%0d got rel=%b lng=%b want rel=%b lng=0",
                     f, rel, lng, (f == 6));
         end
      end
      btn = 1'b1;
      for (int e = 1; e <= 15; e++) begin
         tick();
         checks++;
         if ({press, lng} !== {(e == 6), 1'b0}) begin
            failures++;
            $display("FAIL long_hold15 edge=%0d got prs=%b lng=%b want prs=%b lng=0",
                     e, press, lng, (e == 6));
         end
      end
      btn = 1'b0;
      for (int f = 1; f <= 10; f++) begin
         tick();
         checks++;
         if ({rel, lng} !== {(f == 6), 1'b0}) begin
            failures++;
            $display("FAIL long_rel15 edge=%0d got rel=%b lng=%b want rel=%b lng=0",
                     f, rel, lng, (f == 6));
         end
      end
      checks++;
      if (count !== 4'd2) begin
         failures++;
         $display("FAIL long_count got %0d want 2", count);
      end
   endtask

   task automatic test_wrap();
      int presses;
      presses = 0;
      do_reset();
      for (int p = 0; p < 17; p++) begin
         btn = 1'b1;
         for (int e = 1; e <= 8; e++) begin
            tick();
            if (press === 1'b1) presses++;
            checks++;
            if ({press, rel} !== {(e == 6), 1'b0}) begin
               failures++;
               $display("FAIL wrap_press p=%0d edge=%0d got prs=%b rel=%b want prs=%b rel=0",
                        p, e, press, rel, (e == 6));
            end
         end
         checks++;
         if (count !== 4'(p + 1)) begin
            failures++;
            $display("FAIL wrap_count p=%0d got %0d want %0d", p, count, 4'(p + 1));
         end
         btn = 1'b0;
         for (int f = 1; f <= 8; f++) begin
            tick();
            checks++;
            if ({press, rel} !== {1'b0, (f == 6)}) begin
               failures++;
               $display("FAIL wrap_release p=%0d edge=%0d got prs=%b rel=%b want prs=0 rel=%b",
                        p, f, press, rel, (f == 6));
            end
         end
      end
      checks++;
      if ((count !== 4'd1) || (presses != 17)) begin
         failures++;
         $display("FAIL wrap_final got cnt=%0d presses=%0d want cnt=1 presses=17", count, presses);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      btn = 1'b1;
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({level, press, rel, lng, count} !== '0) begin
         failures++;
         $display("FAIL async_pend_clear got lvl=%b prs=%b cnt=%0d want 0", level, press, count);
      end
      repeat (2) tick();
      btn = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({level, press, count} !== '0) begin
            failures++;
            $display("FAIL async_pend_after cyc=%0d got lvl=%b prs=%b cnt=%0d want 0",
                     i, level, press, count);
         end
      end
      btn = 1'b1;
      repeat (8) tick();
      checks++;
      if ({level, count} !== {1'b1, 4'd1}) begin
         failures++;
         $display("FAIL async_held got lvl=%b cnt=%0d want lvl=1 cnt=1", level, count);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({level, press, rel, lng, count} !== '0) begin
         failures++;
         $display("FAIL async_held_clear got lvl=%b cnt=%0d want lvl=0 cnt=0", level, count);
      end
      tick();
      btn = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      btn = 1'b0;
      test_reset();
      test_bounce();
      test_clean_press();
      test_long_press();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Input-side counterpart to the LED blinker: conditions a raw mechanical push-button into clean, clk_i-synchronous events for the fabric. The block does three things:
- synchronises the asynchronous pin;
- filters contact bounce with a cycle-count debounce FSM;
- emits one-cycle press/release strobes, a debounced level, a wrapping press counter, and an optional long-press strobe.

Sits directly behind a board button pin; its outputs drive LED/demo logic.

Parameters:
DEBOUNCE_CYCLES, 1250000, consecutive stable synchronised cycles required to accept a new level (10 ms at 125 MHz); legal range >= 2.
LONG_CYCLES, 125000000, cycles after press_o at which long_o fires (1 s at 125 MHz); legal range >= 1.
CNT_W, 8, width of press counter count_o.

Ports:
clk_i  input  1  single system clock, all logic on posedge.
rst_i  input  1  asynchronous, active-high reset.
btn_i  input  1  raw button pin, asynchronous, active-high (1 = pressed).
level_o  output  1  debounced button level.
press_o  output  1  one-cycle strobe on accepted 0->1 transition.
release_o  output  1  one-cycle strobe on accepted 1->0 transition.
long_o  output  1  one-cycle strobe on long press (see Optional Feature).
count_o  output  CNT_W  number of accepted presses, modulo 2^CNT_W.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - both sync flops, the FSM, the debounce counter and the hold counter clear to 0; FSM goes to RELEASED.
  - level_o=0, press_o=0, release_o=0, long_o=0, count_o=0.
  - Reset asserted mid-debounce or mid-hold aborts that operation with no strobe.
  - Release is sampled on clk_i; the first edge after release behaves as a normal post-reset cycle.
- Synchroniser: btn_i passes through a 2-flop chain; s denotes the second flop. The FSM sees only s.
- Counter widths: each counter is $clog2 of its terminal value plus 1 bit; no overflow within legal parameter ranges.
- FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - RELEASED: if s=1, go to PRESS_PEND with dcnt=1; otherwise stay.
  - PRESS_PEND:
    - s=0: return to RELEASED, dcnt=0, no strobe (bounce rejected).
    - s=1 and dcnt==DEBOUNCE_CYCLES-1: go to PRESSED; press_o=1 for the next cycle; count_o increments; level_o=1; hcnt=0.
    - else: dcnt increments.
  - PRESSED: if s=0, go to RELEASE_PEND with dcnt=1; otherwise stay.
  - RELEASE_PEND:
    - s=1: return to PRESSED, dcnt=0.
    - s=0 and dcnt==DEBOUNCE_CYCLES-1: go to RELEASED; release_o=1 for the next cycle; level_o=0.
    - else: dcnt increments.
- Latency: counting the first posedge that samples btn_i=1 as edge 1, press_o is high in the cycle following edge DEBOUNCE_CYCLES+2. Release latency is identical.
- Strobe rules:
  - press_o and release_o are never both high.
  - Each is exactly one cycle wide.
  - Accepted press and release strobes strictly alternate, starting with press after reset.
- count_o wraps from 2^CNT_W-1 to 0 on the next accepted press. It never changes on release or on rejected bounces.
- Glitch shorter than DEBOUNCE_CYCLES synchronised cycles: no output changes at all.
- level_o changes in the same cycle press_o/release_o assert.

Optional Feature:
Macro BTN_DEBOUNCE_LONGPRESS_EN.
- Defined:
  - Hold counter hcnt increments every cycle in PRESSED and RELEASE_PEND, starting at 0 in the cycle press_o is high.
  - long_o is high for one cycle exactly LONG_CYCLES cycles after the press_o cycle, provided level_o is still 1.
  - hcnt then saturates, so long_o fires at most once per press.
  - A bounce into RELEASE_PEND and back does not restart hcnt.
  - An accepted release before LONG_CYCLES suppresses long_o.
- Undefined: no hcnt logic exists, long_o is tied to 0, and LONG_CYCLES is unused. All other behaviour is identical.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, CNT_W=4 (only scenario 4 needs BTN_DEBOUNCE_LONGPRESS_EN).
1. Reset: hold rst_i=1 with btn_i=1 for 10 cycles -> all outputs 0; deassert, btn_i stays 1 -> press_o high one cycle after edge 6; count_o=1; level_o=1.
2. Bounce rejection: btn_i toggles 1,0,1,0 each for 2 cycles, then 0 -> press_o never asserts; count_o=0; level_o=0.
3. Clean press/release: btn_i=1 for 30 cycles, then 0 -> one press_o, then one release_o 6 edges after the fall; release_o never coincides with press_o.
4. Long press: btn_i=1 for 40 cycles -> long_o high exactly 20 cycles after press_o, once. Repeat with btn_i=1 for 15 cycles -> no long_o. Without the macro -> long_o always 0.
5. Wrap: 17 clean presses -> count_o reads 1 after the 17th press; press_o pulses 17 times.
6. Async reset mid-PRESS_PEND: assert rst_i between posedges 3 cycles into a press -> outputs clear immediately; no press_o; count_o stays 0.
